// File: rtl/dmd_scanner.sv
// dmd_scanner: double-buffered 16x16 dot-matrix refresh engine with tear-free swaps
module dmd_scanner #(
  parameter int PRESCALE = 1000,
  parameter int ON_TICKS = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        enable,
  input  logic        wr_en,
  input  logic [3:0]  wr_row,
  input  logic [15:0] wr_data,
  input  logic        swap_req,
  output logic        DMD_CLR,
  output logic [3:0]  dmd_seg,
  output logic [15:0] dmd_column,
  output logic        DMD_CLK,
  output logic        frame_done,
  output logic        swap_pending
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int HW = ON_TICKS > 1 ? $clog2(ON_TICKS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(ON_TICKS - 1);

  // PARK is the blanked, parked state after reset or while disabled; the first
  // tick after enabling moves it into row 0 BLANK, so BLANK always lasts a full tick.
  typedef enum logic [2:0] {PARK, BLANK, SETUP, LATCH, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    row_q, row_d;
  logic          front_q, front_d;
  logic          pend_q, pend_d;
  logic          clr_q, clr_d;
  logic [3:0]    seg_q, seg_d;
  logic [15:0]   col_q, col_d;
  logic          strobe_q, strobe_d;
  logic          done_q, done_d;
  logic [15:0]   mem_q [2][16];
  logic          tick;
  logic          frame_end;

  assign tick      = enable && cnt_q == CNT_MAX;
  assign frame_end = tick && state_q == HOLD && hold_q == '0 && row_q == 4'd15;

  // Frame store: writes target the buffer that is back before this edge, even on a swap edge
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 16; r++)
          mem_q[b][r] <= '0;
    end else if (wr_en) begin
      mem_q[~front_q][wr_row] <= wr_data;
    end

  // Prescaler, swap bookkeeping and per-row scan FSM next state
  always_comb begin
    cnt_d    = !enable || tick ? '0 : cnt_q + 1'b1;
    front_d  = frame_end && (pend_q || swap_req) ? ~front_q : front_q;
    pend_d   = frame_end ? 1'b0 : pend_q || swap_req;
    state_d  = state_q;
    row_d    = row_q;
    hold_d   = hold_q;
    clr_d    = clr_q;
    seg_d    = seg_q;
    col_d    = col_q;
    strobe_d = strobe_q;
    done_d   = 1'b0;
    if (!enable) begin
      state_d  = PARK;
      row_d    = '0;
      hold_d   = '0;
      clr_d    = 1'b1;
      seg_d    = '0;
      col_d    = '0;
      strobe_d = 1'b0;
    end else if (tick) begin
      case (state_q)
        PARK: state_d = BLANK;
        BLANK: begin
          state_d = SETUP;
          clr_d   = 1'b0;
          seg_d   = row_q;
          col_d   = mem_q[front_q][row_q];
        end
        SETUP: begin
          state_d  = LATCH;
          strobe_d = 1'b1;
        end
        LATCH: begin
          state_d  = HOLD;
          strobe_d = 1'b0;
          hold_d   = HOLD_MAX;
        end
        HOLD: begin
          if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
          end else begin
            state_d = BLANK;
            row_d   = row_q + 4'd1;
            clr_d   = 1'b1;
            col_d   = '0;
            done_d  = row_q == 4'd15;
          end
        end
        default: state_d = PARK;
      endcase
    end
  end

  // Scan state and registered pin drivers
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q  <= PARK;
      cnt_q    <= '0;
      hold_q   <= '0;
      row_q    <= '0;
      front_q  <= 1'b0;
      pend_q   <= 1'b0;
      clr_q    <= 1'b1;
      seg_q    <= '0;
      col_q    <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      row_q    <= row_d;
      front_q  <= front_d;
      pend_q   <= pend_d;
      clr_q    <= clr_d;
      seg_q    <= seg_d;
      col_q    <= col_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end

  assign DMD_CLR      = clr_q;
  assign dmd_seg      = seg_q;
  assign dmd_column   = col_q;
  assign DMD_CLK      = strobe_q;
  assign frame_done   = done_q;
  assign swap_pending = pend_q;
endmodule

// File: tb/tb_dmd_scanner.sv
// tb_dmd_scanner: directed scoreboard bench for dmd_scanner (PRESCALE=2, ON_TICKS=4)
module tb_dmd_scanner;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_row = '0;
  logic [15:0] wr_data = '0;
  logic        swap_req = 1'b0;
  logic        DMD_CLR, DMD_CLK, frame_done, swap_pending;
  logic [3:0]  dmd_seg;
  logic [15:0] dmd_column;
  int          errors = 0;
  int          checks = 0;
  logic [19:0] exp_q[$];
  logic        chk_w = 1'b1;
  logic        mon_prev = 1'b0;
  int          mon_hw = 0;
  logic [19:0] mon_e;
  time         t1;

  dmd_scanner #(.PRESCALE(2), .ON_TICKS(4)) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .wr_en(wr_en), .wr_row(wr_row),
    .wr_data(wr_data), .swap_req(swap_req), .DMD_CLR(DMD_CLR), .dmd_seg(dmd_seg),
    .dmd_column(dmd_column), .DMD_CLK(DMD_CLK), .frame_done(frame_done),
    .swap_pending(swap_pending)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] d0, input logic [15:0] d3);
    for (int i = 0; i < 16; i++)
      exp_q.push_back({4'(i), i == 0 ? d0 : i == 3 ? d3 : 16'h0000});
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!frame_done && n < 400);
    chk(tag, frame_done, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge CLK);
        if (DMD_CLK && !mon_prev) begin
          mon_hw = 1;
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("latch_row", {dmd_seg, dmd_column}, mon_e);
          end
        end else if (DMD_CLK) begin
          mon_hw++;
        end else if (mon_prev && chk_w) begin
          chk("clk_width", mon_hw, 2);
        end
        mon_prev = DMD_CLK;
      end
    join_none
    repeat (3) @(negedge CLK);
    chk("rst_clr", DMD_CLR, 1);
    chk("rst_seg", dmd_seg, 0);
    chk("rst_col", dmd_column, 0);
    chk("rst_clk", DMD_CLK, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_pend", swap_pending, 0);
    push_frame(16'h0000, 16'h0000);
    RESET = 1'b1;
    enable = 1'b1;
    wait_done("t1_done_a");
    t1 = $time;
    chk("t1_drain", exp_q.size(), 0);
    @(negedge CLK);
    chk("t1_pulse", frame_done, 0);
    wait_done("t1_done_b");
    chk("t1_period", 32'(($time - t1) / 10), 224);
    wr_en = 1'b1;
    wr_row = 4'd3;
    wr_data = 16'hA5A5;
    @(negedge CLK);
    wr_en = 1'b0;
    swap_req = 1'b1;
    @(negedge CLK);
    swap_req = 1'b0;
    chk("t2_pend", swap_pending, 1);
    wait_done("t2_done");
    chk("t2_pend_clr", swap_pending, 0);
    push_frame(16'h0000, 16'hA5A5);
    drain("t2_frame");
    wr_en = 1'b1;
    wr_row = 4'd3;
    wr_data = 16'hFFFF;
    @(negedge CLK);
    wr_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_done("t3_done");
      push_frame(16'h0000, 16'hA5A5);
      drain("t3_frame");
    end
    wait_done("t4_sync");
    repeat (223) @(negedge CLK);
    swap_req = 1'b1;
    wr_en = 1'b1;
    wr_row = 4'd0;
    wr_data = 16'h1234;
    @(negedge CLK);
    swap_req = 1'b0;
    wr_en = 1'b0;
    chk("t4_align", frame_done, 1);
    chk("t4_pend", swap_pending, 0);
    push_frame(16'h1234, 16'hFFFF);
    drain("t4_frame");
    wait_done("t5_sync");
    repeat (10) @(negedge CLK);
    swap_req = 1'b1;
    @(negedge CLK);
    swap_req = 1'b0;
    chk("t5_pend_a", swap_pending, 1);
    repeat (40) @(negedge CLK);
    swap_req = 1'b1;
    @(negedge CLK);
    swap_req = 1'b0;
    chk("t5_pend_b", swap_pending, 1);
    wait_done("t5_done");
    chk("t5_pend_clr", swap_pending, 0);
    push_frame(16'h0000, 16'hA5A5);
    drain("t5_frame_a");
    wait_done("t5_done2");
    push_frame(16'h0000, 16'hA5A5);
    drain("t5_frame_b");
    chk_w = 1'b0;
    wait_done("t6_sync");
    repeat (102) @(negedge CLK);
    chk("t6_latch", DMD_CLK, 1);
    chk("t6_row", dmd_seg, 7);
    enable = 1'b0;
    @(negedge CLK);
    chk("t6_off_clk", DMD_CLK, 0);
    chk("t6_off_clr", DMD_CLR, 1);
    chk("t6_off_seg", dmd_seg, 0);
    chk("t6_off_col", dmd_column, 0);
    repeat (9) @(negedge CLK);
    enable = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t6_pre_setup", DMD_CLR, 1);
    chk_w = 1'b1;
    push_frame(16'h0000, 16'hA5A5);
    @(negedge CLK);
    chk("t6_setup_clr", DMD_CLR, 0);
    chk("t6_setup_seg", dmd_seg, 0);
    drain("t6_frame");
    chk_w = 1'b0;
    wait_done("t7_sync");
    repeat (5) @(negedge CLK);
    swap_req = 1'b1;
    @(negedge CLK);
    swap_req = 1'b0;
    chk("t7_pend", swap_pending, 1);
    repeat (40) @(negedge CLK);
    chk("t7_row3", dmd_column, 16'hA5A5);
    RESET = 1'b0;
    #1;
    chk("t7_rst_clr", DMD_CLR, 1);
    chk("t7_rst_seg", dmd_seg, 0);
    chk("t7_rst_col", dmd_column, 0);
    chk("t7_rst_clk", DMD_CLK, 0);
    chk("t7_rst_done", frame_done, 0);
    chk("t7_rst_pend", swap_pending, 0);
    push_frame(16'h0000, 16'h0000);
    @(negedge CLK);
    RESET = 1'b1;
    wait_done("t7_done_a");
    drain("t7_frame_a");
    chk_w = 1'b1;
    swap_req = 1'b1;
    @(negedge CLK);
    swap_req = 1'b0;
    wait_done("t7_done_b");
    chk("t7_pend_clr", swap_pending, 0);
    push_frame(16'h0000, 16'h0000);
    drain("t7_frame_b");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
